// File: rtl/prog_loader.sv
// Byte-stream program loader: frames UART bytes into 18-bit words, writes the
// CPU program memory, and holds the CPU in reset until a load checks out.
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES   = 1000000,
  parameter bit          HOLD_AFTER_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_port_wr,
  output logic [9:0]  mem_port_addr,
  output logic [17:0] mem_port_data,
  output logic        cpu_rst,
  output logic        busy,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StHunt,
    StCntHi,
    StCntLo,
    StB0,
    StB1,
    StB2,
    StCsum
  } state_e;

  state_e      state_q;
  logic [TW-1:0] timer_q;
  logic [9:0]  cnt_q;
  logic [9:0]  addr_q;
  logic [7:0]  sum_q;
  logic [7:0]  sum_next;
  logic [1:0]  b0_q;
  logic [7:0]  b1_q;
  logic        cpu_hold_q;
  logic        timed_out;

  always_comb begin
    sum_next  = sum_q + rx_data;
    timed_out = (state_q != StHunt) && (timer_q == TimerLast);
  end

  // cpu_rst follows rst directly so the CPU is held for the whole reset window
  // and sits at HOLD_AFTER_RESET as soon as rst drops.
  assign cpu_rst = cpu_hold_q | rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StHunt;
      timer_q       <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      sum_q         <= '0;
      b0_q          <= '0;
      b1_q          <= '0;
      cpu_hold_q    <= HOLD_AFTER_RESET;
      mem_port_wr   <= 1'b0;
      mem_port_addr <= '0;
      mem_port_data <= '0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      mem_port_wr <= 1'b0;
      load_done   <= 1'b0;

      if (timed_out) begin
        // Expiry beats a byte arriving on the same cycle.
        state_q    <= StHunt;
        busy       <= 1'b0;
        load_err   <= 1'b1;
        cpu_hold_q <= 1'b1;
        timer_q    <= '0;
      end else begin
        if (state_q != StHunt) begin
          timer_q <= timer_q + 1'b1;
        end
        if (rx_valid) begin
          timer_q <= '0;
          unique case (state_q)
            StHunt: begin
              if (rx_data == SYNC_BYTE) begin
                state_q    <= StCntHi;
                busy       <= 1'b1;
                cpu_hold_q <= 1'b1;
                load_err   <= 1'b0;
                addr_q     <= '0;
                sum_q      <= '0;
              end
            end
            StCntHi: begin
              cnt_q[9:8] <= rx_data[1:0];
              sum_q      <= sum_next;
              state_q    <= StCntLo;
            end
            StCntLo: begin
              cnt_q[7:0] <= rx_data;
              sum_q      <= sum_next;
              state_q    <= StB0;
            end
            StB0: begin
              b0_q    <= rx_data[1:0];
              sum_q   <= sum_next;
              state_q <= StB1;
            end
            StB1: begin
              b1_q    <= rx_data;
              sum_q   <= sum_next;
              state_q <= StB2;
            end
            StB2: begin
              mem_port_wr   <= 1'b1;
              mem_port_addr <= addr_q;
              mem_port_data <= {b0_q, b1_q, rx_data};
              addr_q        <= addr_q + 1'b1;
              sum_q         <= sum_next;
              state_q       <= (addr_q == cnt_q) ? StCsum : StB0;
            end
            StCsum: begin
              state_q <= StHunt;
              busy    <= 1'b0;
              sum_q   <= sum_next;
              if (sum_next == 8'h00) begin
                load_done  <= 1'b1;
                cpu_hold_q <= 1'b0;
              end else begin
                load_err <= 1'b1;
              end
            end
            default: begin
              state_q <= StHunt;
              busy    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a frame-level model predicts writes and
// load status, a monitor scoreboards every memory write strobe.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        mem_port_wr;
  logic [9:0]  mem_port_addr;
  logic [17:0] mem_port_data;
  logic        cpu_rst;
  logic        busy;
  logic        load_done;
  logic        load_err;

  always #5 clk = ~clk;

  prog_loader #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(50),
    .HOLD_AFTER_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .mem_port_wr(mem_port_wr),
    .mem_port_addr(mem_port_addr),
    .mem_port_data(mem_port_data),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .load_done(load_done),
    .load_err(load_err)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected writes as {addr, data}, popped by the monitor.
  logic [27:0] exp_q[$];
  logic [17:0] fw[$];
  logic        prev_wr = 1'b0;

  always @(negedge clk) begin
    if (mem_port_wr === 1'b1) begin
      check("wr_width", {31'd0, prev_wr}, 0);
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(exp_q.size()), 1);
      end else begin
        automatic logic [27:0] e = exp_q.pop_front();
        check("wr_addr", {22'd0, mem_port_addr}, {22'd0, e[27:18]});
        check("wr_data", {14'd0, mem_port_data}, {14'd0, e[17:0]});
      end
    end
    prev_wr <= mem_port_wr;
  end

  // Called at a negedge; returns at the negedge after the byte is sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic crst, input logic bsy);
    check({tag, "_done"}, {31'd0, load_done}, {31'd0, done});
    check({tag, "_err"}, {31'd0, load_err}, {31'd0, err});
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, crst});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, bsy});
  endtask

  // Builds the frame for the words in fw; delta is added to the correct CSUM.
  task automatic send_frame(input string tag, input logic [7:0] delta, input bit gaps);
    logic [7:0] bq[$];
    logic [7:0] sum;
    logic [7:0] cnt_hi;
    logic [7:0] b0;
    int         n;
    bit         good;
    n      = fw.size() - 1;
    cnt_hi = {6'($urandom), 2'(n >> 8)};
    bq.push_back(cnt_hi);
    bq.push_back(8'(n));
    for (int i = 0; i <= n; i++) begin
      b0 = {6'($urandom), fw[i][17:16]};
      bq.push_back(b0);
      bq.push_back(fw[i][15:8]);
      bq.push_back(fw[i][7:0]);
      exp_q.push_back({10'(i), fw[i]});
    end
    sum = 8'h00;
    foreach (bq[i]) sum = sum + bq[i];
    bq.push_back(8'(8'h00 - sum + delta));
    good = (delta == 8'h00);

    send_byte(8'hA5);
    check_status({tag, "_sync"}, 1'b0, 1'b0, 1'b1, 1'b1);
    foreach (bq[i]) begin
      send_byte(bq[i]);
      if (gaps && i != bq.size() - 1) idle($urandom_range(0, 3));
    end
    check_status({tag, "_end"}, good, !good, !good, 1'b0);
    idle(1);
    check({tag, "_done_pulse"}, {31'd0, load_done}, 0);
    idle(1);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst = 1'b1;
    idle(3);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_wr", {31'd0, mem_port_wr}, 0);
    check("rst_addr", {22'd0, mem_port_addr}, 0);
    check("rst_data", {14'd0, mem_port_data}, 0);
    check("rst_err", {31'd0, load_err}, 0);
    rst = 1'b0;
    idle(1);
    check_status("post_rst", 1'b0, 1'b0, 1'b1, 1'b0);

    // Stray bytes in hunt
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 8'hA4)));
    check("stray_busy", {31'd0, busy}, 0);

    // Single-word frame from the reference vector
    exp_q.push_back({10'd0, 18'h23456});
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h74);
    check_status("single", 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("single_hold_addr", {22'd0, mem_port_addr}, 0);
    check("single_hold_data", {14'd0, mem_port_data}, 32'h23456);
    check("single_writes_left", 32'(exp_q.size()), 0);

    // Three words back to back, then bad checksum, then a recovering frame
    fw = '{18'h3FFFF, 18'h00001, 18'h1ABCD};
    send_frame("three", 8'h00, 1'b0);
    send_frame("three_bad", 8'h01, 1'b0);
    fw = '{18'h2A5A5, 18'h000A5};
    send_frame("sync_in_data", 8'h00, 1'b1);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      fw.delete();
      for (int i = 0; i <= int'($urandom_range(0, 15)); i++) fw.push_back(18'($urandom));
      send_frame($sformatf("rand%0d", f),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 1'b1);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) send_byte(8'($urandom_range(0, 8'hA4)));
    end

    // Timeout after CNT_LO + B0
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    idle(49);
    check("to_busy_before", {31'd0, busy}, 1);
    idle(1);
    check_status("to_expired", 1'b0, 1'b1, 1'b1, 1'b0);
    send_byte(8'h34);
    check("to_ignore_busy", {31'd0, busy}, 0);

    // Longest tolerated gap, then a byte landing on the expiry edge
    send_byte(8'hA5);
    idle(48);
    send_byte(8'h00);
    check("gap48_busy", {31'd0, busy}, 1);
    check("gap48_err", {31'd0, load_err}, 0);
    idle(49);
    send_byte(8'h00);
    check_status("expiry_byte", 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of word 1
    exp_q.push_back({10'd0, 18'h1C0DE});
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'hC0);
    send_byte(8'hDE);
    send_byte(8'h02);
    send_byte(8'h11);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_rst_cpu_rst", {31'd0, cpu_rst}, 1);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_addr", {22'd0, mem_port_addr}, 0);
    check("mid_rst_data", {14'd0, mem_port_data}, 0);
    check("mid_rst_err", {31'd0, load_err}, 0);
    send_byte(8'h00);
    send_byte(8'h00);
    check("mid_rst_stray_busy", {31'd0, busy}, 0);
    idle(2);
    check("mid_rst_writes_left", 32'(exp_q.size()), 0);

    fw = '{18'h12345};
    send_frame("final", 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
